// File: rtl/tx_os_scheduler_pkg.sv
// tx_os_pkg: shared definitions for the transmit ordered-set scheduler.
// Contents:
//   DSEL_* : 4-bit lane data bus selector codes (shared with the data bus)
//   state_t: scheduler state enum
//   dsel_of: selector code driven for a given state
//   is_training: true for every state that transmits training sets
package tx_os_pkg;

  localparam logic [3:0] DSEL_SLOS1 = 4'd0;
  localparam logic [3:0] DSEL_SLOS2 = 4'd1;
  localparam logic [3:0] DSEL_G3TS1 = 4'd2;
  localparam logic [3:0] DSEL_G3TS2 = 4'd3;
  localparam logic [3:0] DSEL_G4TS1 = 4'd4;
  localparam logic [3:0] DSEL_G4TS2 = 4'd5;
  localparam logic [3:0] DSEL_G4TS3 = 4'd6;
  localparam logic [3:0] DSEL_G4TS4 = 4'd7;
  localparam logic [3:0] DSEL_DATA  = 4'd8;
  localparam logic [3:0] DSEL_IDLE  = 4'd9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SLOS1,
    ST_SLOS2,
    ST_G3TS1,
    ST_G3TS2,
    ST_G4TS1,
    ST_G4TS2,
    ST_G4TS3,
    ST_G4TS4,
    ST_DATA
  } state_t;

  function automatic logic [3:0] dsel_of(input state_t s);
    case (s)
      ST_SLOS1: return DSEL_SLOS1;
      ST_SLOS2: return DSEL_SLOS2;
      ST_G3TS1: return DSEL_G3TS1;
      ST_G3TS2: return DSEL_G3TS2;
      ST_G4TS1: return DSEL_G4TS1;
      ST_G4TS2: return DSEL_G4TS2;
      ST_G4TS3: return DSEL_G4TS3;
      ST_G4TS4: return DSEL_G4TS4;
      ST_DATA:  return DSEL_DATA;
      default:  return DSEL_IDLE;
    endcase
  endfunction

  function automatic logic is_training(input state_t s);
    return !((s == ST_IDLE) || (s == ST_DATA));
  endfunction

endpackage

// File: rtl/tx_os_scheduler_if.sv
// tx_os_scheduler_if: control and status bundle between the LTSSM / lane
// data bus and the ordered-set scheduler.
//   master (LTSSM + data bus side): drives train_start, train_abort, gen4,
//     partner_ready, os_sent; observes d_sel, busy, train_done, set_cnt.
//   slave (scheduler): the reverse directions.
interface tx_os_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             train_start;
  logic             train_abort;
  logic             gen4;
  logic             partner_ready;
  logic             os_sent;
  logic [3:0]       d_sel;
  logic             busy;
  logic             train_done;
  logic [CNT_W-1:0] set_cnt;

  modport master (
    output train_start, train_abort, gen4, partner_ready, os_sent,
    input  d_sel, busy, train_done, set_cnt
  );

  modport slave (
    input  train_start, train_abort, gen4, partner_ready, os_sent,
    output d_sel, busy, train_done, set_cnt
  );
endinterface

// File: rtl/tx_os_scheduler_phase_counter.sv
// os_phase_counter: counts completed ordered sets within one training phase.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   count_en  : one set finished in a training phase
//   clear     : return the count to zero (has priority over count_en)
//   limit     : phase limit for the current phase
//   cnt       : sets completed so far
//   limit_hit : count_en this cycle and the phase limit is (or already was) reached
module os_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             limit_hit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_limit;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign at_limit = (cnt_q == limit);
  // at_limit covers a gated phase that is already saturated and still waiting
  assign limit_hit = count_en && (at_limit || (cnt_inc == limit));
  assign cnt       = cnt_q;

  // Saturate at the limit instead of wrapping when the phase cannot exit yet.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !at_limit) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_os_scheduler.sv
// tx_os_scheduler: walks the lane data bus selector through the Gen3 or
// Gen4 link-training ordered-set order, then hands the bus to DATA.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tx_os_scheduler_if.slave
//              (train_start/train_abort/gen4/partner_ready/os_sent in,
//               d_sel/busy/train_done/set_cnt out, all outputs registered)
module tx_os_scheduler
  import tx_os_pkg::*;
#(
  parameter int N_SLOS1 = 2,
  parameter int N_SLOS2 = 2,
  parameter int N_TS1   = 16,
  parameter int N_TS2   = 16,
  parameter int N_TS3   = 16,
  parameter int N_TS4   = 16,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  tx_os_scheduler_if.slave    bus
);

  state_t           state_q, state_d;
  logic             gen4_q, gen4_d;
  logic             ready_q, ready_d;
  logic [3:0]       d_sel_q, d_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt;
  logic             limit_hit;
  logic             in_train;
  logic             count_en;
  logic             cnt_clear;
  logic             ready_eff;

  assign in_train  = is_training(state_q);
  assign count_en  = bus.os_sent && in_train;
  // A phase change (including abort) clears the counter in the same cycle.
  assign cnt_clear = !in_train || (state_d != state_q);
  // partner_ready coincident with the limiting os_sent still allows the exit.
  assign ready_eff = ready_q || bus.partner_ready;

  always_comb begin
    case (state_q)
      ST_SLOS1:           limit = CNT_W'(N_SLOS1);
      ST_SLOS2:           limit = CNT_W'(N_SLOS2);
      ST_G3TS1, ST_G4TS1: limit = CNT_W'(N_TS1);
      ST_G3TS2, ST_G4TS2: limit = CNT_W'(N_TS2);
      ST_G4TS3:           limit = CNT_W'(N_TS3);
      ST_G4TS4:           limit = CNT_W'(N_TS4);
      default:            limit = '0;
    endcase
  end

  os_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk       (clk),
    .rst       (rst),
    .count_en  (count_en),
    .clear     (cnt_clear),
    .limit     (limit),
    .cnt       (cnt),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gen4_q  <= 1'b0;
      ready_q <= 1'b0;
      d_sel_q <= DSEL_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gen4_q  <= gen4_d;
      ready_q <= ready_d;
      d_sel_q <= d_sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Both TS1 states share the ready gating; the latched generation picks
  // which TS2 follows.
  always_comb begin
    state_d = state_q;
    gen4_d  = gen4_q;
    ready_d = ready_q;
    if (bus.train_abort) begin
      state_d = ST_IDLE;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.train_start) begin
            gen4_d  = bus.gen4;
            state_d = bus.gen4 ? ST_G4TS1 : ST_SLOS1;
          end
        end
        ST_SLOS1: if (limit_hit) state_d = ST_SLOS2;
        ST_SLOS2: if (limit_hit) state_d = ST_G3TS1;
        ST_G3TS1, ST_G4TS1: begin
          if (bus.partner_ready) ready_d = 1'b1;
          if (limit_hit && ready_eff) begin
            state_d = gen4_q ? ST_G4TS2 : ST_G3TS2;
            ready_d = 1'b0;
          end
        end
        ST_G3TS2: if (limit_hit) state_d = ST_DATA;
        ST_G4TS2: if (limit_hit) state_d = ST_G4TS3;
        ST_G4TS3: if (limit_hit) state_d = ST_G4TS4;
        ST_G4TS4: if (limit_hit) state_d = ST_DATA;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registers track state_q.
  always_comb begin
    d_sel_d = dsel_of(state_d);
    busy_d  = is_training(state_d);
    done_d  = (state_d == ST_DATA) && (state_q != ST_DATA);
  end

  assign bus.d_sel      = d_sel_q;
  assign bus.busy       = busy_q;
  assign bus.train_done = done_q;
  assign bus.set_cnt    = cnt;

endmodule

// File: tb/tb_tx_os_scheduler.sv
// tb_tx_os_scheduler: randomized scoreboard bench for tx_os_scheduler.
// The reference model tracks mode / phase index / set count from the
// ordered-set rules and queues every expected selector change; a monitor
// pops the queue whenever the DUT changes d_sel or pulses train_done.
module tb_tx_os_scheduler;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  tx_os_scheduler_if #(.CNT_W(CNT_W)) bus ();

  tx_os_scheduler #(
    .N_SLOS1 (2),
    .N_SLOS2 (2),
    .N_TS1   (16),
    .N_TS2   (16),
    .N_TS3   (16),
    .N_TS4   (16),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int dsel;
    int busy;
    int done;
    int cyc;
  } exp_t;

  typedef enum int {M_IDLE, M_TRAIN, M_DATA} mode_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_dsel = 9;

  mode_t m_mode = M_IDLE;
  int    m_ph = 0;
  int    m_cnt = 0;
  bit    m_gen4 = 1'b0;
  bit    m_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int phaseLimit(input int ph);
    if (m_gen4) return 16;
    return (ph < 2) ? 2 : 16;
  endfunction

  function automatic int phaseDsel(input int ph);
    return m_gen4 ? (4 + ph) : ph;
  endfunction

  function automatic bit inTs1();
    return (m_mode == M_TRAIN) && (m_ph == (m_gen4 ? 0 : 2));
  endfunction

  function automatic int modelDsel();
    if (m_mode == M_IDLE) return 9;
    if (m_mode == M_DATA) return 8;
    return phaseDsel(m_ph);
  endfunction

  function automatic bit reachedPh(input int target);
    if (target == 4) return m_mode == M_DATA;
    return (m_mode == M_TRAIN) && (m_ph == target);
  endfunction

  task automatic pushExp(input int dsel, input int busy, input int done);
    exp_t e;
    e.dsel = dsel;
    e.busy = busy;
    e.done = done;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Reference model: one call per clock with the inputs of that cycle.
  task automatic modelStep(input bit start, input bit abort, input bit g4, input bit pr, input bit os);
    int lim;
    bit ts1;
    if (abort && m_mode != M_IDLE) begin
      m_mode  = M_IDLE;
      m_cnt   = 0;
      m_ready = 1'b0;
      pushExp(9, 0, 0);
    end else if (m_mode == M_IDLE) begin
      if (start && !abort) begin
        m_gen4  = g4;
        m_mode  = M_TRAIN;
        m_ph    = 0;
        m_cnt   = 0;
        m_ready = 1'b0;
        pushExp(phaseDsel(0), 1, 0);
      end
    end else if (m_mode == M_TRAIN) begin
      ts1 = inTs1();
      lim = phaseLimit(m_ph);
      if (ts1 && pr) m_ready = 1'b1;
      if (os) begin
        if ((m_cnt + 1 >= lim) && (!ts1 || m_ready)) begin
          m_cnt   = 0;
          m_ready = 1'b0;
          m_ph++;
          if (m_ph == 4) begin
            m_mode = M_DATA;
            pushExp(8, 0, 1);
          end else begin
            pushExp(phaseDsel(m_ph), 1, 0);
          end
        end else begin
          m_cnt = (m_cnt + 1 > lim) ? lim : m_cnt + 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit start, input bit abort, input bit g4, input bit pr, input bit os);
    @(negedge clk);
    checkOutput("set_cnt", int'(bus.set_cnt), m_cnt);
    checkOutput("d_sel", int'(bus.d_sel), modelDsel());
    checkOutput("busy", int'(bus.busy), (m_mode == M_TRAIN) ? 1 : 0);
    bus.train_start   = start;
    bus.train_abort   = abort;
    bus.gen4          = g4;
    bus.partner_ready = pr;
    bus.os_sent       = os;
    modelStep(start, abort, g4, pr, os);
  endtask

  // pr_mode: 0 never, 1 random pulses in TS1, 2 level in TS1, 3 only outside TS1
  function automatic bit prVal(input int pr_mode);
    case (pr_mode)
      1:       return inTs1() && ($urandom_range(3, 0) == 0);
      2:       return inTs1();
      3:       return !inTs1();
      default: return 1'b0;
    endcase
  endfunction

  task automatic sendSet(input int gap, input int pr_mode);
    repeat (gap) applyStimulus(1'b0, 1'b0, 1'b0, prVal(pr_mode), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, prVal(pr_mode), 1'b1);
  endtask

  task automatic runTo(input int target, input int gap_lo, input int gap_hi, input int pr_mode);
    int n;
    n = 0;
    while (!reachedPh(target) && n < 400) begin
      sendSet(int'($urandom_range(gap_hi, gap_lo)), pr_mode);
      n++;
    end
    if (!reachedPh(target)) checkOutput("run_timeout_sets", n, 0);
  endtask

  task automatic startTrain(input bit g4);
    applyStimulus(1'b1, 1'b0, g4, 1'b0, 1'b0);
  endtask

  task automatic abortTrain(input bit os);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, os);
  endtask

  task automatic asyncReset();
    @(negedge clk);
    bus.train_start   = 1'b0;
    bus.train_abort   = 1'b0;
    bus.gen4          = 1'b0;
    bus.partner_ready = 1'b0;
    bus.os_sent       = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_dsel", int'(bus.d_sel), 9);
    checkOutput("async_rst_busy", int'(bus.busy), 0);
    checkOutput("async_rst_set_cnt", int'(bus.set_cnt), 0);
    if (m_mode != M_IDLE) pushExp(9, 0, 0);
    m_mode  = M_IDLE;
    m_cnt   = 0;
    m_ready = 1'b0;
    m_gen4  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every selector change or train_done pulse consumes one entry.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (int'(bus.d_sel) != last_dsel || bus.train_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output_queue", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_d_sel", int'(bus.d_sel), e.dsel);
        checkOutput("sb_busy", int'(bus.busy), e.busy);
        checkOutput("sb_train_done", int'(bus.train_done), e.done);
        checkOutput("sb_cycle", cyc, e.cyc);
      end
      last_dsel = int'(bus.d_sel);
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int ph;
    bus.train_start   = 1'b0;
    bus.train_abort   = 1'b0;
    bus.gen4          = 1'b0;
    bus.partner_ready = 1'b0;
    bus.os_sent       = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_d_sel", int'(bus.d_sel), 9);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_train_done", int'(bus.train_done), 0);
    checkOutput("reset_set_cnt", int'(bus.set_cnt), 0);

    $display("[TB] os_sent and partner_ready while idle");
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] Gen3 happy path, os_sent every 64 cycles");
    startTrain(1'b0);
    runTo(4, 63, 63, 2);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] Gen4 path");
    abortTrain(1'b0);
    startTrain(1'b1);
    runTo(4, 0, 2, 2);

    $display("[TB] TS1 wait without partner_ready");
    abortTrain(1'b0);
    startTrain(1'b0);
    runTo(2, 0, 1, 3);
    repeat (66) sendSet(int'($urandom_range(1, 0)), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendSet(0, 0);
    runTo(4, 0, 1, 2);

    $display("[TB] partner_ready coincident with 16th TS1");
    abortTrain(1'b0);
    startTrain(1'b1);
    repeat (15) sendSet(int'($urandom_range(2, 0)), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    runTo(4, 0, 1, 2);

    $display("[TB] abort in G4TS3 together with os_sent");
    abortTrain(1'b0);
    startTrain(1'b1);
    runTo(2, 0, 1, 2);
    repeat (3) sendSet(0, 0);
    abortTrain(1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    startTrain(1'b0);
    runTo(4, 0, 1, 2);

    $display("[TB] randomized rounds");
    repeat (8) begin
      abortTrain(1'($urandom_range(1, 0)));
      startTrain(1'($urandom_range(1, 0)));
      ph = int'($urandom_range(4, 0));
      runTo(ph, 0, 3, 1);
      repeat ($urandom_range(3, 0)) sendSet(int'($urandom_range(2, 0)), 1);
    end

    $display("[TB] asynchronous reset in G3TS2");
    abortTrain(1'b0);
    startTrain(1'b0);
    runTo(3, 0, 1, 2);
    repeat (4) sendSet(0, 0);
    asyncReset();
    startTrain(1'b0);
    runTo(4, 0, 1, 2);

    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("scoreboard_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
